pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/update controller for the program-counter register of the 54-instruction MIPS core. It drives the PC register's next-value input and its hold control (1 = hold, 0 = load). It runs the instruction-memory fetch handshake and selects the next PC from sequential, branch, jump, exception and eret sources. It also raises CP0 exception writes (EPC/Cause) for syscall/break/teq, misaligned targets and fetch timeouts.

Parameters:
RESET_VECTOR, 32'h00400000, PC value after reset; pc_next reset value
EXC_VECTOR, 32'h00400004, exception handler entry
FETCH_TIMEOUT, 15, max CLK cycles waiting for imem_ack before instruction bus error (1..255)

Ports:
CLK  in  1  single clock; all state updates on posedge
reset_n  in  1  asynchronous, active-low reset
pc_cur  in  32  current PC register output
pc_next  out  32  value loaded into the PC register
pc_hold  out  1  1 = PC register holds, 0 = loads pc_next
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address (= pc_cur)
imem_ack  in  1  instruction word valid this cycle
instr_valid  out  1  one-cycle pulse: fetched instruction is ready for decode
exec_done  in  1  datapath finished the current instruction
br_taken  in  1  conditional branch taken;  br_target  in  32
jmp  in  1  j/jal/jr/jalr;  jmp_target  in  32
exc_req  in  1  syscall/break/teq trap;  exc_cause  in  5  its cause code
eret  in  1  return from exception;  epc_in  in  32  EPC from CP0
epc_we  out  1  one-cycle CP0 EPC/Cause write strobe
epc_out  out  32  EPC value;  cause_out  out  5  Cause.ExcCode
state_dbg  out  3  current FSM state

Behaviour:
- Reset (reset_n=0, async): state=IDLE, pc_next=RESET_VECTOR, pc_hold=1, imem_req=0, instr_valid=0, epc_we=0, epc_out=0, cause_out=0, timeout counter=0. Reset mid-fetch or mid-exec aborts immediately. imem_req drops without waiting for ack.
- States: IDLE -> FETCH -> EXEC -> UPDATE -> FETCH.
- IDLE: one cycle after reset release, then FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_cur, counter increments each cycle.
  - If imem_ack: pulse instr_valid for one cycle and go to EXEC; counter clears.
  - If the counter reaches FETCH_TIMEOUT without ack: epc_out=pc_cur, cause_out=6 (IBE), epc_we=1, pc_next=EXC_VECTOR, go to UPDATE.
  - Ack on the timeout cycle counts as success.
- EXEC: imem_req=0. Wait for exec_done; all redirect inputs are sampled only in the exec_done cycle. When exec_done is sampled, select pc_next by priority:
  1. exc_req: EXC_VECTOR; epc_out=pc_cur, cause_out=exc_cause, epc_we=1.
  2. eret: epc_in.
  3. jmp: jmp_target.
  4. br_taken: br_target.
  5. Otherwise: pc_cur+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  - Misaligned result (pc_next[1:0]!=0) from eret/jmp/br: replace with EXC_VECTOR, epc_out=pc_cur, cause_out=4 (AdEL), epc_we=1.
  - Then go to UPDATE.
- UPDATE: pc_hold=0 for exactly one CLK cycle. The PC register captures on the falling edge inside this cycle, so pc_cur is new at the next posedge. Next state is FETCH.
- pc_hold=1 in all other states. epc_we is high only in the UPDATE cycle that follows an exception decision.
- Simultaneous exc_req+eret+jmp+br_taken: exception wins. exec_done in IDLE/FETCH/UPDATE is ignored.
- Instruction latency (zero-wait memory): FETCH 1 + EXEC ≥1 + UPDATE 1 = 3 cycles minimum per instruction.
- State encoding: IDLE=0, FETCH=1, EXEC=2, UPDATE=3.

Decomposition:
- Package pc_seq_pkg holds:
  - state encoding
  - ExcCode constants: INT=0, ADEL=4, IBE=6, SYS=8, BP=9, TR=13
  - default vectors
- Sub-module pc_next_sel: the priority/alignment-check selector. Inputs are the redirect signals plus pc_cur. Outputs are next_pc, is_exc and exc_code. It is purely combinational.
- Top holds the FSM, timeout counter and registered outputs.

Test Plan:
- Reset release, imem_ack after 1 cycle, exec_done, no redirects:
  - pc_next=32'h00400004, one pc_hold=0 cycle, instr_valid one pulse.
  - Next imem_addr=32'h00400004.
- pc_cur=32'h00400010, exec_done with jmp=1 (jmp_target=32'h00400100) and br_taken=1 (br_target=32'h00400200) -> pc_next=32'h00400100, epc_we=0.
- pc_cur=32'h00400020, exec_done with exc_req=1, exc_cause=8 and eret=1 -> pc_next=32'h00400004, epc_out=32'h00400020, cause_out=8, epc_we one cycle.
- br_taken with br_target=32'h00400102 -> pc_next=EXC_VECTOR, cause_out=4. Then eret with epc_in=32'h00400040 -> pc_next=32'h00400040.
- imem_ack never asserted -> after 15 FETCH cycles cause_out=6, epc_out=pc_cur, pc_next=EXC_VECTOR. Second run with ack on cycle 15 -> normal fetch, no exception.
- reset_n pulled low in EXEC and in FETCH -> imem_req=0 and pc_hold=1 immediately (asynchronous), state_dbg=0. Wrap case: pc_cur=32'hFFFFFFFC -> pc_next=32'h00000000.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM encoding,
// CP0 ExcCode values and default vectors.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3
    } pc_state_t;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_IBE  = 5'd6;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_TR   = 5'd13;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0040_0004;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: trap > eret > jump > branch > sequential,
// with misaligned redirect targets converted into an AdEL exception.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] i_pc_cur,
    input  logic        i_exc_req,
    input  logic [4:0]  i_exc_cause,
    input  logic        i_eret,
    input  logic [31:0] i_epc_in,
    input  logic        i_jmp,
    input  logic [31:0] i_jmp_target,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    output logic [31:0] o_next_pc,
    output logic        o_is_exc,
    output logic [4:0]  o_exc_code
);

    logic [31:0] w_target;
    logic        w_redirect;

    always_comb begin
        w_target   = i_pc_cur + 32'd4;
        w_redirect = 1'b1;
        if (i_eret) begin
            w_target = i_epc_in;
        end else if (i_jmp) begin
            w_target = i_jmp_target;
        end else if (i_br_taken) begin
            w_target = i_br_target;
        end else begin
            w_redirect = 1'b0;
        end
    end

    always_comb begin
        o_next_pc  = w_target;
        o_is_exc   = 1'b0;
        o_exc_code = EXC_INT;
        if (i_exc_req) begin
            o_next_pc  = EXC_VECTOR;
            o_is_exc   = 1'b1;
            o_exc_code = i_exc_cause;
        end else if (w_redirect && (w_target[1:0] != 2'b00)) begin
            // Sequential pc_cur+4 keeps alignment, so only redirects can fault.
            o_next_pc  = EXC_VECTOR;
            o_is_exc   = 1'b1;
            o_exc_code = EXC_ADEL;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter fetch/update controller: runs the imem fetch handshake,
// chooses the next PC and raises CP0 EPC/Cause writes on exceptions.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR  = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR    = DEF_EXC_VECTOR,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic [4:0]  exc_cause,
    input  logic        eret,
    input  logic [31:0] epc_in,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic [4:0]  cause_out,
    output logic [2:0]  state_dbg
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    pc_state_t   r_state;
    pc_state_t   w_state_nxt;
    logic [7:0]  r_cnt;
    logic [31:0] r_pc_next;
    logic        r_instr_valid;
    logic        r_epc_we;
    logic [31:0] r_epc_out;
    logic [4:0]  r_cause_out;

    logic [31:0] w_sel_pc;
    logic        w_sel_exc;
    logic [4:0]  w_sel_code;
    logic        w_timeout;

    pc_next_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_sel (
        .i_pc_cur     (pc_cur),
        .i_exc_req    (exc_req),
        .i_exc_cause  (exc_cause),
        .i_eret       (eret),
        .i_epc_in     (epc_in),
        .i_jmp        (jmp),
        .i_jmp_target (jmp_target),
        .i_br_taken   (br_taken),
        .i_br_target  (br_target),
        .o_next_pc    (w_sel_pc),
        .o_is_exc     (w_sel_exc),
        .o_exc_code   (w_sel_code)
    );

    // An ack arriving on the final allowed cycle still wins over the timeout.
    assign w_timeout = (r_state == ST_FETCH) && !imem_ack && (r_cnt == TIMEOUT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_FETCH;
            ST_FETCH:  if (imem_ack || w_timeout) w_state_nxt = (imem_ack) ? ST_EXEC : ST_UPDATE;
            ST_EXEC:   if (exec_done) w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = ST_FETCH;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 8'd0;
            r_pc_next     <= RESET_VECTOR;
            r_instr_valid <= 1'b0;
            r_epc_we      <= 1'b0;
            r_epc_out     <= 32'd0;
            r_cause_out   <= 5'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_instr_valid <= (r_state == ST_FETCH) && imem_ack;
            r_epc_we      <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_cnt <= 8'd0;
                    end else if (w_timeout) begin
                        r_cnt       <= 8'd0;
                        r_pc_next   <= EXC_VECTOR;
                        r_epc_we    <= 1'b1;
                        r_epc_out   <= pc_cur;
                        r_cause_out <= EXC_IBE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        r_pc_next <= w_sel_pc;
                        if (w_sel_exc) begin
                            r_epc_we    <= 1'b1;
                            r_epc_out   <= pc_cur;
                            r_cause_out <= w_sel_code;
                        end
                    end
                end
                default: r_cnt <= 8'd0;
            endcase
        end
    end

    // Hold and request decode straight from state so an async reset drops them at once.
    assign pc_hold     = (r_state != ST_UPDATE);
    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = pc_cur;
    assign pc_next     = r_pc_next;
    assign instr_valid = r_instr_valid;
    assign epc_we      = r_epc_we;
    assign epc_out     = r_epc_out;
    assign cause_out   = r_cause_out;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register that loads
// pc_next on the falling edge whenever pc_hold is low.
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h0040_0004;

    logic        CLK;
    logic        reset_n;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        exec_done;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic        eret;
    logic [31:0] epc_in;
    logic        epc_we;
    logic [31:0] epc_out;
    logic [4:0]  cause_out;
    logic [2:0]  state_dbg;

    logic [31:0] pc_reg;
    logic        ovr_en;
    logic [31:0] ovr_val;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .RESET_VECTOR  (RV),
        .EXC_VECTOR    (EV),
        .FETCH_TIMEOUT (15)
    ) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .pc_hold     (pc_hold),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .exc_req     (exc_req),
        .exc_cause   (exc_cause),
        .eret        (eret),
        .epc_in      (epc_in),
        .epc_we      (epc_we),
        .epc_out     (epc_out),
        .cause_out   (cause_out),
        .state_dbg   (state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK or negedge reset_n) begin
        if (!reset_n) pc_reg <= RV;
        else if (!pc_hold) pc_reg <= pc_next;
    end

    assign pc_cur = ovr_en ? ovr_val : pc_reg;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 0; exec_done = 0; br_taken = 0; br_target = 0;
        jmp = 0; jmp_target = 0; exc_req = 0; exc_cause = 0;
        eret = 0; epc_in = 0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        ovr_en  = 1'b1;
        ovr_val = v;
    endtask

    // From FETCH: ack at once, then one exec_done cycle with the given redirects; ends in UPDATE.
    task automatic run_instr(input logic ex, input logic [4:0] cause, input logic er,
                             input logic [31:0] epc, input logic j, input logic [31:0] jt,
                             input logic b, input logic [31:0] bt);
        imem_ack = 1;
        tick();
        imem_ack = 0;
        exc_req = ex; exc_cause = cause; eret = er; epc_in = epc;
        jmp = j; jmp_target = jt; br_taken = b; br_target = bt;
        exec_done = 1;
        tick();
        clear_inputs();
        ovr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        ovr_en = 0; ovr_val = 0;
        clear_inputs();
        repeat (3) tick();
        checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
        checks++; if (pc_next !== RV) begin errors++; $display("FAIL reset_pc_next: got %h expected %h", pc_next, RV); end
        checks++; if (pc_hold !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got hold=%b req=%b expected hold=1 req=0", pc_hold, imem_req); end
        checks++; if (instr_valid !== 1'b0 || epc_we !== 1'b0) begin errors++; $display("FAIL reset_pulses: got iv=%b we=%b expected 0 0", instr_valid, epc_we); end
        checks++; if (epc_out !== 32'd0 || cause_out !== 5'd0) begin errors++; $display("FAIL reset_epc_cause: got %h/%0d expected 0/0", epc_out, cause_out); end
        reset_n = 1;
        tick();
        checks++; if (state_dbg !== 3'd1 || imem_req !== 1'b1 || imem_addr !== RV) begin errors++; $display("FAIL first_fetch: got st=%0d req=%b addr=%h expected 1 1 %h", state_dbg, imem_req, imem_addr, RV); end
    endtask

    task automatic test_sequential();
        imem_ack = 1;
        tick();
        imem_ack = 0;
        checks++; if (state_dbg !== 3'd2 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL seq_exec_entry: got st=%0d iv=%b req=%b expected 2 1 0", state_dbg, instr_valid, imem_req); end
        tick();
        checks++; if (state_dbg !== 3'd2 || instr_valid !== 1'b0) begin errors++; $display("FAIL seq_exec_wait: got st=%0d iv=%b expected 2 0", state_dbg, instr_valid); end
        exec_done = 1;
        tick();
        exec_done = 0;
        checks++; if (state_dbg !== 3'd3 || pc_hold !== 1'b0 || pc_next !== 32'h0040_0004 || epc_we !== 1'b0) begin errors++; $display("FAIL seq_update: got st=%0d hold=%b pc=%h we=%b expected 3 0 00400004 0", state_dbg, pc_hold, pc_next, epc_we); end
        tick();
        checks++; if (state_dbg !== 3'd1 || pc_hold !== 1'b1 || imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL seq_next_fetch: got st=%0d hold=%b addr=%h expected 1 1 00400004", state_dbg, pc_hold, imem_addr); end
    endtask

    task automatic test_jump_priority();
        set_pc(32'h0040_0010);
        run_instr(0, 5'd0, 0, 32'd0, 1, 32'h0040_0100, 1, 32'h0040_0200);
        checks++; if (pc_next !== 32'h0040_0100 || epc_we !== 1'b0) begin errors++; $display("FAIL jmp_over_br: got pc=%h we=%b expected 00400100 0", pc_next, epc_we); end
        tick();
        checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL jmp_fetch_addr: got %h expected 00400100", imem_addr); end
    endtask

    task automatic test_exception();
        set_pc(32'h0040_0020);
        run_instr(1, 5'd8, 1, 32'h0040_0080, 1, 32'h0040_0300, 1, 32'h0040_0400);
        checks++; if (pc_next !== EV || epc_we !== 1'b1) begin errors++; $display("FAIL exc_pc_we: got pc=%h we=%b expected %h 1", pc_next, epc_we, EV); end
        checks++; if (epc_out !== 32'h0040_0020 || cause_out !== 5'd8) begin errors++; $display("FAIL exc_epc_cause: got %h/%0d expected 00400020/8", epc_out, cause_out); end
        tick();
        checks++; if (epc_we !== 1'b0 || state_dbg !== 3'd1) begin errors++; $display("FAIL exc_we_pulse: got we=%b st=%0d expected 0 1", epc_we, state_dbg); end
    endtask

    task automatic test_misaligned();
        set_pc(32'h0040_0030);
        run_instr(0, 5'd0, 0, 32'd0, 0, 32'd0, 1, 32'h0040_0102);
        checks++; if (pc_next !== EV || cause_out !== 5'd4 || epc_out !== 32'h0040_0030 || epc_we !== 1'b1) begin errors++; $display("FAIL br_adel: got pc=%h cause=%0d epc=%h we=%b expected %h 4 00400030 1", pc_next, cause_out, epc_out, epc_we, EV); end
        tick();
        run_instr(0, 5'd0, 1, 32'h0040_0040, 0, 32'd0, 0, 32'd0);
        checks++; if (pc_next !== 32'h0040_0040 || epc_we !== 1'b0 || cause_out !== 5'd4) begin errors++; $display("FAIL eret_return: got pc=%h we=%b cause=%0d expected 00400040 0 4", pc_next, epc_we, cause_out); end
        tick();
        run_instr(0, 5'd0, 0, 32'd0, 1, 32'h0040_0201, 0, 32'd0);
        checks++; if (pc_next !== EV || cause_out !== 5'd4 || epc_out !== 32'h0040_0040 || epc_we !== 1'b1) begin errors++; $display("FAIL jmp_adel: got pc=%h cause=%0d epc=%h we=%b expected %h 4 00400040 1", pc_next, cause_out, epc_out, epc_we, EV); end
        tick();
    endtask

    task automatic test_timeout();
        set_pc(32'h0040_0050);
        exec_done = 1;
        repeat (14) tick();
        checks++; if (state_dbg !== 3'd1 || epc_we !== 1'b0) begin errors++; $display("FAIL timeout_early: got st=%0d we=%b expected 1 0", state_dbg, epc_we); end
        exec_done = 0;
        tick();
        checks++; if (state_dbg !== 3'd3 || cause_out !== 5'd6 || epc_out !== 32'h0040_0050 || pc_next !== EV || epc_we !== 1'b1) begin errors++; $display("FAIL timeout_ibe: got st=%0d cause=%0d epc=%h pc=%h we=%b expected 3 6 00400050 %h 1", state_dbg, cause_out, epc_out, pc_next, epc_we, EV); end
        ovr_en = 0;
        tick();
        checks++; if (state_dbg !== 3'd1 || imem_addr !== EV) begin errors++; $display("FAIL timeout_refetch: got st=%0d addr=%h expected 1 %h", state_dbg, imem_addr, EV); end
        repeat (14) tick();
        imem_ack = 1;
        tick();
        imem_ack = 0;
        checks++; if (state_dbg !== 3'd2 || instr_valid !== 1'b1 || epc_we !== 1'b0) begin errors++; $display("FAIL ack_last_cycle: got st=%0d iv=%b we=%b expected 2 1 0", state_dbg, instr_valid, epc_we); end
        exec_done = 1;
        tick();
        exec_done = 0;
        checks++; if (pc_next !== 32'h0040_0008 || epc_we !== 1'b0 || cause_out !== 5'd6) begin errors++; $display("FAIL ack_last_seq: got pc=%h we=%b cause=%0d expected 00400008 0 6", pc_next, epc_we, cause_out); end
        tick();
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        run_instr(0, 5'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        checks++; if (pc_next !== 32'h0000_0000 || epc_we !== 1'b0) begin errors++; $display("FAIL wrap: got pc=%h we=%b expected 00000000 0", pc_next, epc_we); end
        tick();
        checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_fetch_addr: got %h expected 00000000", imem_addr); end
    endtask

    task automatic test_async_reset();
        imem_ack = 1;
        tick();
        imem_ack = 0;
        #2 reset_n = 0;
        #1;
        checks++; if (state_dbg !== 3'd0 || pc_hold !== 1'b1 || imem_req !== 1'b0 || pc_next !== RV) begin errors++; $display("FAIL rst_in_exec: got st=%0d hold=%b req=%b pc=%h expected 0 1 0 %h", state_dbg, pc_hold, imem_req, pc_next, RV); end
        tick();
        reset_n = 1;
        tick();
        checks++; if (state_dbg !== 3'd1 || imem_req !== 1'b1) begin errors++; $display("FAIL rst_release_fetch: got st=%0d req=%b expected 1 1", state_dbg, imem_req); end
        #2 reset_n = 0;
        #1;
        checks++; if (state_dbg !== 3'd0 || imem_req !== 1'b0 || pc_hold !== 1'b1) begin errors++; $display("FAIL rst_in_fetch: got st=%0d req=%b hold=%b expected 0 0 1", state_dbg, imem_req, pc_hold); end
        tick();
        reset_n = 1;
        tick();
        run_instr(0, 5'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        #1 reset_n = 0;
        #1;
        checks++; if (pc_hold !== 1'b1 || state_dbg !== 3'd0) begin errors++; $display("FAIL rst_in_update: got hold=%b st=%0d expected 1 0", pc_hold, state_dbg); end
        tick();
        reset_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_priority();
        test_exception();
        test_misaligned();
        test_timeout();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
